bcd_counter_scan: RTL and testbench
===================================

// Module: bcd_counter_scan
// PURPOSE
//  Synchronous N-digit cascaded decimal (BCD) counter with parallel load and wrap carry.
//  Drives a time-multiplexed 7-segment display: one shared a..g bus plus a one-hot digit select.
//  Fully synchronous, single clock; replaces ripple-clocked per-digit counters in display paths.
// PARAMETERS
//  N_DIGITS  4    number of BCD digits (1..8); count range 0 .. 10^N_DIGITS-1
//  SCAN_DIV  1000 clk cycles each digit is shown before the scanner advances (>=1)
// PORTS
//  clk       in   1           rising-edge clock
//  reset     in   1           synchronous, active-high reset
//  en        in   1           count enable: one step per clk with en=1
//  load      in   1           parallel load strobe
//  load_val  in   4*N_DIGITS  load value; digit k at [4k+3:4k], digit 0 = least significant
//  up_dn     in   1           1 = count up, 0 = count down (port exists only with BCD_UPDOWN_EN)
//  count     out  4*N_DIGITS  current BCD value, same packing as load_val
//  carry_out out  1           1-cycle pulse on wrap
//  load_err  out  1           1-cycle pulse when load_val held an invalid digit (>9)
//  seg       out  7           {a,b,c,d,e,f,g}, 1 = segment lit
//  dig_sel   out  N_DIGITS    one-hot select of the digit shown on seg
// BEHAVIOUR
//  - Reset: count=0, carry_out=0, load_err=0, prescaler=0, scan_idx=0, seg=7'b0000000, dig_sel=0.
//  - Priority per edge: reset > load > en. load and en together: load wins, no step.
//  - load: each digit of load_val >9 is stored as 0, all valid digits as given; load_err=1 next cycle.
//    carry_out=0 on a load cycle.
//  - Up step: digit 0 increments; digit k increments only when all lower digits are 9 and roll to 0.
//    All-9s -> all-0s, carry_out=1 in the cycle after that edge.
//  - Down step (macro only): mirror image. Digit borrows at 0 -> 9; all-0s -> all-9s, carry_out=1.
//  - en=0: count holds, carry_out=0. carry_out never asserts for two cycles from a single wrap.
//  - Scanner is free-running and independent of en/load.
//    prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and scan_idx advances.
//    scan_idx wraps N_DIGITS-1 -> 0.
//  - seg and dig_sel are registered every clk:
//    dig_sel <= 1<<scan_idx; seg <= decode(count digit[scan_idx]).
//    This gives 1-cycle latency from a count or scan_idx change, and seg/dig_sel always align.
//  - Decode table, digits 0..9: 7E,30,6D,79,33,5B,5F,70,7F,7B (hex of {a..g}).
//    Any other code shows 7'b0000001; unreachable internally, kept for safety.
//  - Mid-operation reset returns everything to reset values on that edge; no partial carry survives.
// CONFIGURATION
//  BCD_UPDOWN_EN defined: up_dn port present, bidirectional counting as above.
//  BCD_UPDOWN_EN undefined: no up_dn port; counter is up-only; down logic is not elaborated.
// STRUCTURE
//  Package bcd_pkg:
//    typedef logic [3:0] bcd_t; typedef logic [6:0] seg7_t.
//    SEG_BLANK = 7'b0000001.
//    function bcd_to_seg7(bcd_t) returning seg7_t.
//  Sub-module bcd_digit: one decade with en_in/up/load/load_d inputs and tc_out terminal-count output.
//    Generated N_DIGITS times; tc chained by combinational AND.
//  Scanner (prescaler, scan_idx, output registers) stays in the top.
// TESTING
//  1. Reset held 3 cycles, N=4 -> count=0000, carry_out=0, load_err=0, seg=00, dig_sel=0000.
//  2. load_val=16'h9998, en=1 for 2 cycles -> count 9999 then 0000; carry_out=1 exactly once.
//  3. load=1 with en=1, load_val=16'h1234 -> count=1234 next cycle, no step.
//     load_val=16'h12A4 -> count=1204, load_err pulses 1 cycle.
//  4. SCAN_DIV=3, count=16'h0729 -> dig_sel 0001,0010,0100,1000 each held 3 cycles.
//     seg matches per digit: 7B,6D,70,7E.
//  5. BCD_UPDOWN_EN, up_dn=0, count=0000, en=1 -> 9999 with carry_out=1; count=0100 -> 0099.
//  6. Reset asserted mid-count at 0357 with en=1 -> next cycle count=0000, dig_sel=0, seg=00.

Source files
------------

// File: rtl/bcd_counter_scan_pkg.sv
// Shared types and helpers for the BCD counter / 7-segment scan block.
// Package name: bcd_pkg.
package bcd_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg7_t;

    // Pattern shown for any code outside 0..9 (only the g segment lit).
    localparam seg7_t SEG_BLANK = 7'b0000001;
    localparam bcd_t  BCD_MAX   = 4'd9;

    // True when a nibble holds a legal decimal digit.
    function automatic logic bcd_valid(input bcd_t d);
        return (d <= BCD_MAX);
    endfunction

    // Segment pattern {a,b,c,d,e,f,g}, 1 = lit.
    function automatic seg7_t bcd_to_seg7(input bcd_t d);
        seg7_t s;
        case (d)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h5F;
            4'd7:    s = 7'h70;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h7B;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_counter_scan_digit.sv
// One decimal decade. Load has priority over stepping; an illegal load
// digit is stored as 0. tc_out flags that this decade is at its terminal
// value (9 counting up, 0 counting down) so the next decade may step.
// Optional macro: BCD_UPDOWN_EN enables the down-counting path.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en_in,
    input  logic up,
    input  logic load,
    input  bcd_t load_d,
    output bcd_t digit_o,
    output logic tc_out
);

    bcd_t digit_q, digit_d;

    // Next digit value: load, else step in the selected direction.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_valid(load_d) ? load_d : 4'd0;
        end else if (en_in) begin
`ifdef BCD_UPDOWN_EN
            if (up) begin
                digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
            end
`else
            if (up) begin
                digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
            end
`endif
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) digit_q <= 4'd0;
        else       digit_q <= digit_d;
    end

`ifdef BCD_UPDOWN_EN
    assign tc_out = up ? (digit_q == BCD_MAX) : (digit_q == 4'd0);
`else
    assign tc_out = up & (digit_q == BCD_MAX);
`endif
    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_counter_scan.sv
// N-digit synchronous BCD counter with parallel load, wrap carry pulse and a
// free-running multiplexed 7-segment scanner.
// Optional macro: BCD_UPDOWN_EN adds the up_dn port and down counting.
module bcd_counter_scan
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
`ifdef BCD_UPDOWN_EN
    input  logic                  up_dn,
`endif
    output logic [4*N_DIGITS-1:0] count,
    output logic                  carry_out,
    output logic                  load_err,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   dig_sel
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                up_w;
    bcd_t                digit_w [N_DIGITS];
    logic [N_DIGITS-1:0] tc_w;
    // chain_w[k] = enable reaching decade k; chain_w[N_DIGITS] = full wrap.
    logic [N_DIGITS:0]   chain_w;

`ifdef BCD_UPDOWN_EN
    assign up_w = up_dn;
`else
    assign up_w = 1'b1;
`endif

    assign chain_w[0] = en;

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk     (clk),
            .reset   (reset),
            .en_in   (chain_w[k]),
            .up      (up_w),
            .load    (load),
            .load_d  (load_val[4*k +: 4]),
            .digit_o (digit_w[k]),
            .tc_out  (tc_w[k])
        );
        assign chain_w[k+1]     = chain_w[k] & tc_w[k];
        assign count[4*k +: 4]  = digit_w[k];
    end

    // Flag any illegal nibble in the load value.
    logic any_bad_w;
    always_comb begin
        any_bad_w = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (!bcd_valid(load_val[4*k +: 4])) any_bad_w = 1'b1;
        end
    end

    // Status pulses: wrap carry (suppressed by load) and load error.
    logic carry_q, load_err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= chain_w[N_DIGITS] & ~load;
            load_err_q <= load & any_bad_w;
        end
    end

    // Prescaler and scan index next-state.
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Select the digit currently being scanned.
    bcd_t sel_bcd_w;
    always_comb begin
        sel_bcd_w = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IW'(k)) sel_bcd_w = digit_w[k];
        end
    end

    // Scanner state and registered display outputs (always aligned).
    seg7_t               seg_q;
    logic [N_DIGITS-1:0] dig_sel_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            idx_q     <= '0;
            seg_q     <= '0;
            dig_sel_q <= '0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            seg_q     <= bcd_to_seg7(sel_bcd_w);
            dig_sel_q <= N_DIGITS'(1) << idx_q;
        end
    end

    assign carry_out = carry_q;
    assign load_err  = load_err_q;
    assign seg       = seg_q;
    assign dig_sel   = dig_sel_q;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Bench for bcd_counter_scan (N_DIGITS=4, SCAN_DIV=3). Directed vectors with
// hand-computed expectations; down-count vectors only with BCD_UPDOWN_EN.
module tb_bcd_counter_scan;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   load_val = '0;
  logic          up_dn = 1'b1;
  logic [15:0]   count;
  logic          carry_out;
  logic          load_err;
  logic [6:0]    seg;
  logic [N-1:0]  dig_sel;

  // Entry: {chk_scan, count[15:0], carry, load_err, seg[6:0], dig_sel[3:0]}
  logic [29:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  bcd_counter_scan #(.N_DIGITS(N), .SCAN_DIV(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
`ifdef BCD_UPDOWN_EN
    .up_dn     (up_dn),
`endif
    .count     (count),
    .carry_out (carry_out),
    .load_err  (load_err),
    .seg       (seg),
    .dig_sel   (dig_sel)
  );

  // ---------------- driver ----------------
  // Applies inputs for the next edge and queues the state expected after it.
  task automatic drive(input logic r, input logic e, input logic l,
                       input logic [15:0] lv, input logic ud,
                       input logic [15:0] ec, input logic ecar, input logic elerr,
                       input logic cs, input logic [6:0] es, input logic [3:0] ed);
    @(negedge clk);
    reset    = r;
    en       = e;
    load     = l;
    load_val = lv;
    up_dn    = ud;
    exp_q.push_back({cs, ec, ecar, elerr, es, ed});
  endtask

  task automatic step(input logic e, input logic l, input logic [15:0] lv,
                      input logic ud, input logic [15:0] ec, input logic ecar,
                      input logic elerr);
    drive(1'b0, e, l, lv, ud, ec, ecar, elerr, 1'b0, 7'h00, 4'h0);
  endtask

  task automatic scan(input logic l, input logic [15:0] lv, input logic [15:0] ec,
                      input logic [6:0] es, input logic [3:0] ed);
    drive(1'b0, 1'b0, l, lv, 1'b1, ec, 1'b0, 1'b0, 1'b1, es, ed);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [29:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (count !== e[28:13]) begin
        n_fail++;
        $display("FAIL count: got %h want %h at %0t", count, e[28:13], $time);
      end
      n_checks++;
      if (carry_out !== e[12]) begin
        n_fail++;
        $display("FAIL carry_out: got %b want %b at %0t", carry_out, e[12], $time);
      end
      n_checks++;
      if (load_err !== e[11]) begin
        n_fail++;
        $display("FAIL load_err: got %b want %b at %0t", load_err, e[11], $time);
      end
      if (e[29]) begin
        n_checks++;
        if (seg !== e[10:4]) begin
          n_fail++;
          $display("FAIL seg: got %h want %h at %0t", seg, e[10:4], $time);
        end
        n_checks++;
        if (dig_sel !== e[3:0]) begin
          n_fail++;
          $display("FAIL dig_sel: got %b want %b at %0t", dig_sel, e[3:0], $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held 3 cycles: everything zero, display blank.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 7'h00, 4'h0);

    // Scanner right after reset, loading 0729 on the first edge.
    // First edge still shows the pre-load digit 0; then 9,2,7,0 for 3 cycles each.
    scan(1'b1, 16'h0729, 16'h0729, 7'h7E, 4'b0001);
    scan(1'b0, 16'h0000, 16'h0729, 7'h7B, 4'b0001);
    scan(1'b0, 16'h0000, 16'h0729, 7'h7B, 4'b0001);
    for (int i = 0; i < 3; i++) scan(1'b0, 16'h0000, 16'h0729, 7'h6D, 4'b0010);
    for (int i = 0; i < 3; i++) scan(1'b0, 16'h0000, 16'h0729, 7'h70, 4'b0100);
    for (int i = 0; i < 3; i++) scan(1'b0, 16'h0000, 16'h0729, 7'h7E, 4'b1000);
    scan(1'b0, 16'h0000, 16'h0729, 7'h7B, 4'b0001);

    // Up wrap: 9998 -> 9999 -> 0000 with a single carry pulse.
    step(1'b0, 1'b1, 16'h9998, 1'b1, 16'h9998, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h9999, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

    // Multi-digit ripple 0199 -> 0200.
    step(1'b0, 1'b1, 16'h0199, 1'b1, 16'h0199, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b0, 1'b0);

    // Load beats enable; invalid digits stored as 0 with a one-cycle error pulse.
    step(1'b1, 1'b1, 16'h1234, 1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h12A4, 1'b1, 16'h1204, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1204, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'hF9F9, 1'b1, 16'h0909, 1'b0, 1'b1);
    // Loading all-9s with en: no step and no carry on the load cycle.
    step(1'b1, 1'b1, 16'h9999, 1'b1, 16'h9999, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h9999, 1'b0, 1'b0);

`ifdef BCD_UPDOWN_EN
    // Down counting: borrow wrap 0000 -> 9999 with carry, and 0100 -> 0099.
    step(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h9999, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h9998, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0100, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0099, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0098, 1'b0, 1'b0);
`endif

    // Mid-count reset at 0357 with en high.
    step(1'b0, 1'b1, 16'h0356, 1'b1, 16'h0356, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0357, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 7'h00, 4'h0);

    // Reset while a wrap is pending: no carry survives.
    step(1'b0, 1'b1, 16'h9999, 1'b1, 16'h9999, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 7'h00, 4'h0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
